// File: rtl/event_unit_pkg.sv
// Shared types for the event unit: hardware mutex client state and opcodes.
package event_unit_pkg;

  // Client FSM states; IDLE is encoded as zero so a reset client reads as all-zero.
  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_LOCK   = 3'd1,
    MC_WAIT   = 3'd2,
    MC_MSG    = 3'd3,
    MC_UNLOCK = 3'd4,
    MC_RESP   = 3'd5
  } mutex_client_state_e;

  // Core bus opcode carried on we_i.
  localparam logic MUTEX_CLIENT_OP_LOCK   = 1'b0;
  localparam logic MUTEX_CLIENT_OP_UNLOCK = 1'b1;

endpackage

// File: rtl/hw_mutex_client.sv
// Per-core hardware mutex client: turns blocking lock/unlock bus accesses into
// single-cycle pulses toward the mutex units, waits for the grant event and
// returns the mutex message. Tracks owned mutexes and flags misuse.
//
// Core handshake: a request is accepted in the cycle where req_i && gnt_o;
// gnt_o is only high in IDLE, so at most one transaction is outstanding.
// Exactly one response follows as a single-cycle rvalid_o pulse, with rdata_o
// and err_o valid only in that cycle. A reset abandons the transaction silently.
module hw_mutex_client
  import event_unit_pkg::*;
#(
  parameter int NB_MUTEX    = 2,
  parameter int MUTEX_MSG_W = 32,
  parameter int WAIT_CNT_W  = 16,
  localparam int ID_W       = (NB_MUTEX > 1) ? $clog2(NB_MUTEX) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_i,
  input  logic                            we_i,
  input  logic [ID_W-1:0]                 id_i,
  input  logic [MUTEX_MSG_W-1:0]          wdata_i,
  output logic                            gnt_o,
  output logic                            rvalid_o,
  output logic [MUTEX_MSG_W-1:0]          rdata_o,
  output logic                            err_o,
  output logic [NB_MUTEX-1:0]             lock_req_o,
  output logic [NB_MUTEX-1:0]             unlock_req_o,
  output logic [MUTEX_MSG_W-1:0]          mutex_msg_wdata_o,
  input  logic [NB_MUTEX*MUTEX_MSG_W-1:0] mutex_msg_rdata_i,
  input  logic [NB_MUTEX-1:0]             mutex_event_i,
  output logic [NB_MUTEX-1:0]             owned_o,
  output logic [WAIT_CNT_W-1:0]           wait_cycles_o,
  output mutex_client_state_e             state_o
);

  mutex_client_state_e state_q, state_d;
  logic [ID_W-1:0]        id_q;
  logic                   op_q;
  logic                   err_q;
  logic [MUTEX_MSG_W-1:0] wdata_q;
  logic [MUTEX_MSG_W-1:0] msg_q;
  logic [MUTEX_MSG_W-1:0] msg_sel;
  logic [NB_MUTEX-1:0]    owned_q;
  logic [NB_MUTEX-1:0]    id_mask;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q;

  assign id_mask = NB_MUTEX'(1) << id_q;

  // Select the message slice belonging to the latched mutex id.
  always_comb begin
    msg_sel = '0;
    for (int k = 0; k < NB_MUTEX; k++) begin
      if (id_q == ID_W'(k)) msg_sel = mutex_msg_rdata_i[k*MUTEX_MSG_W +: MUTEX_MSG_W];
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= MC_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; the grant event is honoured already in the LOCK cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: begin
        if (req_i) begin
          if (we_i == MUTEX_CLIENT_OP_UNLOCK) state_d = owned_q[id_i] ? MC_UNLOCK : MC_RESP;
          else                                state_d = owned_q[id_i] ? MC_RESP : MC_LOCK;
        end
      end
      MC_LOCK:   state_d = mutex_event_i[id_q] ? MC_MSG : MC_WAIT;
      MC_WAIT:   if (mutex_event_i[id_q]) state_d = MC_MSG;
      MC_MSG:    state_d = MC_RESP;
      MC_UNLOCK: state_d = MC_RESP;
      MC_RESP:   state_d = MC_IDLE;
      default:   state_d = MC_IDLE;
    endcase
  end

  // Datapath registers: latched request, ownership bitmap, wait counter, message.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      id_q       <= '0;
      op_q       <= MUTEX_CLIENT_OP_LOCK;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      msg_q      <= '0;
      owned_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        MC_IDLE: begin
          if (req_i) begin
            id_q <= id_i;
            op_q <= we_i;
            if (we_i == MUTEX_CLIENT_OP_UNLOCK) begin
              wdata_q <= wdata_i;
              err_q   <= !owned_q[id_i];
            end else begin
              err_q <= owned_q[id_i];
              if (!owned_q[id_i]) wait_cnt_q <= '0;
            end
          end
        end
        MC_WAIT: if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
        // The message is taken one cycle after the event so a handover message
        // registered by the unit at the event edge is already visible.
        MC_MSG: begin
          msg_q       <= msg_sel;
          owned_q     <= owned_q | id_mask;
        end
        MC_UNLOCK: owned_q <= owned_q & ~id_mask;
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state and latched request.
  always_comb begin
    gnt_o        = req_i && (state_q == MC_IDLE);
    lock_req_o   = '0;
    unlock_req_o = '0;
    rvalid_o     = 1'b0;
    rdata_o      = '0;
    err_o        = 1'b0;
    case (state_q)
      MC_LOCK:   lock_req_o   = id_mask;
      MC_UNLOCK: unlock_req_o = id_mask;
      MC_RESP: begin
        rvalid_o = 1'b1;
        err_o    = err_q;
        if (!err_q && op_q == MUTEX_CLIENT_OP_LOCK) rdata_o = msg_q;
      end
      default: ;
    endcase
  end

  assign mutex_msg_wdata_o = wdata_q;
  assign owned_o           = owned_q;
  assign wait_cycles_o     = wait_cnt_q;
  assign state_o           = state_q;

endmodule
